uart_responder: RTL and testbench
=================================

// Module: uart_responder
// PURPOSE
//  8N1 UART transceiver serving the byte-level request/done handshake used by the
//  loopback/command cores. Receives r_valid and t_valid requests, drives rxd/txd
//  pins, and returns ready, r_data, rx_done and tx_done.
//  Sits between the core logic and the board UART pins. Full duplex.
// PARAMETERS
//  CLK_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); must be >= 4
// PORTS
//  clk        in   1  system clock
//  rstn       in   1  asynchronous active-low reset
//  t_data     in   8  byte to send; sampled with an accepted t_valid
//  t_valid    in   1  one-cycle transmit request
//  r_valid    in   1  one-cycle request to arm the receiver for one byte
//  ready      out  1  both engines idle; requests accepted only while high
//  r_data     out  8  last received byte; valid from the rx_done cycle until the next rx_done
//  tx_done    out  1  one-cycle pulse at end of stop bit
//  rx_done    out  1  one-cycle pulse when a byte is in r_data
//  txd        out  1  serial out, idle high
//  rxd        in   1  serial in, asynchronous to clk
// BEHAVIOUR
//  Reset values: ready=0, r_data=0, tx_done=0, rx_done=0, txd=1, parity_err=0.
//   All engines return to IDLE. Reset mid-frame aborts the frame; txd=1 immediately.
//  ready: registered. Equals 1 in the first cycle after reset release.
//   Afterwards ready = tx IDLE AND rx IDLE, evaluated each cycle.
//  Requests while ready=0 are ignored (no queueing). t_valid and r_valid may arrive
//   in the same cycle; both are accepted.
//  ready falls in the cycle after acceptance. It re-rises in the cycle after the last
//   outstanding done pulse.
//  TX FSM: IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE.
//   On accept, t_data is latched. START begins in the next cycle (txd=0).
//   Each bit is held exactly CLK_PER_BIT cycles.
//   tx_done pulses in the last STOP cycle. The FSM is in IDLE in the following cycle.
//  RX: rxd passes through a 2-flop synchronizer. Only the synchronized value is used.
//   RX FSM: IDLE -> ARMED -> START -> DATA(8) -> STOP -> IDLE.
//   ARMED: waits for a synchronized 1->0 transition. If rxd is low when armed, the
//    FSM waits for high and then a fall. Edges while in IDLE are ignored; such bytes
//    are lost.
//   START: samples at CLK_PER_BIT/2 (integer divide). If the sample is 1, it is a
//    false start: return to ARMED.
//   DATA: samples every CLK_PER_BIT cycles from mid-start, LSB first, into a shift register.
//   STOP: mid-bit sample.
//    If 1: r_data <= shift register and rx_done pulses in that same cycle.
//    If 0 (framing error): discard the byte, no rx_done, return to ARMED.
//  Bit counters are 3 bits and wrap 7->0 only on the FSM transition out of DATA.
//  The baud counter width is $clog2(CLK_PER_BIT). It resets to 0 on every state entry.
// CONFIGURATION
//  UART_PARITY_EN defined:
//   Frame becomes 8E1: an even-parity bit follows data bit 7 on TX and on RX.
//   Adds output parity_err (1 bit), registered. It is updated with rx_done and is
//    valid until the next rx_done: 1 if the received parity mismatches.
//   r_data and rx_done are delivered regardless of parity.
//  UART_PARITY_EN undefined: 8N1 only. There is no parity_err port.
// TESTING  (CLK_PER_BIT=4 unless noted)
//  Reset: hold rstn=0 with rxd=1 -> txd=1, ready=0, all dones 0.
//   Release reset -> ready=1 next cycle.
//  TX 0xA5: t_valid pulse -> txd=0 for 4 cycles, then 1,0,1,0,0,1,0,1, then 1.
//   tx_done is high in exactly 1 cycle (the 40th after accept). ready=1 in the next cycle.
//  RX 0x3C: r_valid, then drive 0x3C 8N1 on rxd -> rx_done one pulse, r_data=0x3C.
//   Glitch rxd low for 1 cycle while ARMED -> no rx_done. A following valid frame is received.
//  Duplex: t_valid and r_valid in the same cycle with TX 0x55 and RX 0x81 ->
//   both dones fire, and ready stays 0 until the later done.
//  Ignored requests: t_valid while busy -> no second frame on txd.
//   Frame with stop=0 -> no rx_done, receiver still ARMED.
//  Reset mid-TX (in bit 3) -> txd=1 immediately, no tx_done.
//   UART_PARITY_EN: RX 0x01 with parity bit 0 -> rx_done, parity_err=1.

Source files
------------

// File: rtl/uart_responder.sv
// uart_responder: full-duplex 8N1 UART transceiver behind a one-byte request/done handshake.
// Define UART_PARITY_EN for 8E1 framing and the parity_err output.
module uart_responder #(
  parameter int unsigned CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] t_data,
  input  logic       t_valid,
  input  logic       r_valid,
  output logic       ready,
  output logic [7:0] r_data,
  output logic       tx_done,
  output logic       rx_done,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLK_PER_BIT / 2);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_ARMED, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_t;

  logic r_ready;
  logic w_t_acc;
  logic w_r_acc;

  // Requests are only honoured while both engines are idle.
  assign w_t_acc = t_valid & r_ready;
  assign w_r_acc = r_valid & r_ready;

  // ---------------------------------------------------------------- TX
  tx_state_t      r_tx_state;
  tx_state_t      w_tx_state_nxt;
  logic [CW-1:0]  r_tx_cnt;
  logic [CW-1:0]  w_tx_cnt_nxt;
  logic [2:0]     r_tx_bit;
  logic [2:0]     w_tx_bit_nxt;
  logic [7:0]     r_tx_shift;
  logic [7:0]     w_tx_shift_nxt;
  logic           w_tx_last;
  logic           r_txd;
  logic           w_txd_nxt;
  logic           r_tx_done;
  logic           w_tx_done_nxt;
`ifdef UART_PARITY_EN
  logic           r_tx_par;
  logic           w_tx_par_nxt;
`endif

  assign w_tx_last = (r_tx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
`ifdef UART_PARITY_EN
      r_tx_par   <= w_tx_par_nxt;
`endif
    end
  end

  // Baud counter restarts on every state entry; the shifter exposes the current bit at [0].
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
`ifdef UART_PARITY_EN
    w_tx_par_nxt   = r_tx_par;
`endif
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_t_acc) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = t_data;
`ifdef UART_PARITY_EN
          w_tx_par_nxt   = ^t_data;
`endif
        end
      end
      TX_START: begin
        if (w_tx_last) begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = '0;
        end
      end
      TX_DATA: begin
        if (w_tx_last) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = r_tx_bit + 3'd1;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_state_nxt = TX_PAR;
`else
            w_tx_state_nxt = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PAR: begin
        if (w_tx_last) begin
          w_tx_state_nxt = TX_STOP;
          w_tx_cnt_nxt   = '0;
        end
      end
`endif
      TX_STOP: begin
        if (w_tx_last) begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_cnt_nxt   = '0;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pin and done pulse stay registered.
  always_comb begin
    w_txd_nxt     = 1'b1;
    w_tx_done_nxt = 1'b0;
    case (w_tx_state_nxt)
      TX_START: w_txd_nxt = 1'b0;
      TX_DATA:  w_txd_nxt = w_tx_shift_nxt[0];
`ifdef UART_PARITY_EN
      TX_PAR:   w_txd_nxt = w_tx_par_nxt;
`endif
      TX_STOP:  w_tx_done_nxt = (w_tx_cnt_nxt == CNT_LAST);
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_txd     <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_txd     <= w_txd_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // ---------------------------------------------------------------- RX
  rx_state_t      r_rx_state;
  rx_state_t      w_rx_state_nxt;
  logic [CW-1:0]  r_rx_cnt;
  logic [CW-1:0]  w_rx_cnt_nxt;
  logic [2:0]     r_rx_bit;
  logic [2:0]     w_rx_bit_nxt;
  logic [7:0]     r_rx_shift;
  logic [7:0]     w_rx_shift_nxt;
  logic           r_rxd_s1;
  logic           r_rxd_s2;
  logic           r_rxd_prev;
  logic           w_rx_fall;
  logic           w_rx_last;
  logic           w_rx_done_nxt;
  logic [7:0]     r_data_q;
  logic           r_rx_done;
`ifdef UART_PARITY_EN
  logic           r_rx_par_bit;
  logic           w_rx_par_bit_nxt;
  logic           w_perr_nxt;
  logic           r_parity_err;
`endif

  // rxd is asynchronous; everything downstream uses r_rxd_s2 only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_s1   <= rxd;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
    end
  end

  assign w_rx_fall = r_rxd_prev & ~r_rxd_s2;
  assign w_rx_last = (r_rx_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
`ifdef UART_PARITY_EN
      r_rx_par_bit <= 1'b0;
`endif
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_rx_bit     <= w_rx_bit_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
`ifdef UART_PARITY_EN
      r_rx_par_bit <= w_rx_par_bit_nxt;
`endif
    end
  end

  // Start is checked at mid-bit; later samples fall one full bit apart from there.
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_cnt_nxt     = r_rx_cnt + CW'(1);
    w_rx_bit_nxt     = r_rx_bit;
    w_rx_shift_nxt   = r_rx_shift;
`ifdef UART_PARITY_EN
    w_rx_par_bit_nxt = r_rx_par_bit;
`endif
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (w_r_acc) w_rx_state_nxt = RX_ARMED;
      end
      RX_ARMED: begin
        w_rx_cnt_nxt = '0;
        if (w_rx_fall) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == CNT_MID) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rxd_s2 ? RX_ARMED : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          w_rx_shift_nxt = {r_rxd_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
            w_rx_state_nxt = RX_PAR;
`else
            w_rx_state_nxt = RX_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt     = '0;
          w_rx_par_bit_nxt = r_rxd_s2;
          w_rx_state_nxt   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (w_rx_last) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = r_rxd_s2 ? RX_IDLE : RX_ARMED;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
        w_rx_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_rx_done_nxt = (r_rx_state == RX_STOP) && w_rx_last && r_rxd_s2;
`ifdef UART_PARITY_EN
    w_perr_nxt    = (^r_rx_shift) ^ r_rx_par_bit;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_done    <= 1'b0;
      r_data_q     <= '0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_done <= w_rx_done_nxt;
      if (w_rx_done_nxt) begin
        r_data_q     <= r_rx_shift;
`ifdef UART_PARITY_EN
        r_parity_err <= w_perr_nxt;
`endif
      end
    end
  end

  // ready stays low through the rx_done cycle so it re-rises one cycle after either done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ready <= 1'b0;
    else       r_ready <= (w_tx_state_nxt == TX_IDLE) && (w_rx_state_nxt == RX_IDLE) &&
                          !w_rx_done_nxt;
  end

  assign ready   = r_ready;
  assign r_data  = r_data_q;
  assign tx_done = r_tx_done;
  assign rx_done = r_rx_done;
  assign txd     = r_txd;
`ifdef UART_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_responder.sv
// tb_uart_responder: scoreboard bench for uart_responder at CLK_PER_BIT=4.
// Honours UART_PARITY_EN when the design is built with it.
module tb_uart_responder;

  localparam int unsigned CPB = 4;
`ifdef UART_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [7:0] t_data = 8'h00;
  logic       t_valid = 1'b0;
  logic       r_valid = 1'b0;
  logic       rxd = 1'b1;
  logic       ready;
  logic [7:0] r_data;
  logic       tx_done;
  logic       rx_done;
  logic       txd;
`ifdef UART_PARITY_EN
  logic       parity_err;
  logic       rx_par_flip = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  logic [7:0] tx_q[$];
  logic [8:0] rx_q[$];
  logic [8:0] rx_exp;

  always #5 clk = ~clk;

  uart_responder #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .t_data    (t_data),
    .t_valid   (t_valid),
    .r_valid   (r_valid),
    .ready     (ready),
    .r_data    (r_data),
    .tx_done   (tx_done),
    .rx_done   (rx_done),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .txd       (txd),
    .rxd       (rxd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Done pulse counting and RX scoreboard.
  always @(negedge clk) begin
    if (tx_done === 1'b1) tx_done_cnt++;
    if (rx_done === 1'b1) begin
      rx_done_cnt++;
      check("rx_q_nonempty", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) begin
        rx_exp = rx_q.pop_front();
        check("rx_data", 32'(r_data), 32'(rx_exp[7:0]));
`ifdef UART_PARITY_EN
        check("rx_parity_err", 32'(parity_err), 32'(rx_exp[8]));
`endif
      end
    end
  end

  // TX line decoder; frames interrupted by reset are dropped.
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stp;
    logic       ab;
`ifdef UART_PARITY_EN
    logic       par;
`endif
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        ab = 1'b0;
        repeat (CPB / 2) begin @(negedge clk); if (!rstn) ab = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (!rstn) ab = 1'b1; end
          b[i] = txd;
        end
`ifdef UART_PARITY_EN
        repeat (CPB) begin @(negedge clk); if (!rstn) ab = 1'b1; end
        par = txd;
`endif
        repeat (CPB) begin @(negedge clk); if (!rstn) ab = 1'b1; end
        stp = txd;
        if (!ab) begin
          check("tx_q_nonempty", 32'(tx_q.size() != 0), 32'd1);
          if (tx_q.size() != 0) begin
            e = tx_q.pop_front();
            check("tx_byte", 32'(b), 32'(e));
`ifdef UART_PARITY_EN
            check("tx_parity", 32'(par), 32'(^e));
`endif
            check("tx_stop", 32'(stp), 32'd1);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int target);
    int n;
    n = 0;
    while (rx_done_cnt < target && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    check(tag, 32'(rx_done_cnt), 32'(target));
  endtask

  task automatic arm_rx();
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stp);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rxd = (^d) ^ rx_par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rxd = stp;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin : stim
    logic [NB-1:0] fr;
    int bad;
    int n_done;
    int done_at;
    int c0;
    int n;
    logic gt;
    logic gr;

    // Reset state
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_r_data", 32'(r_data), 32'd0);
`ifdef UART_PARITY_EN
    check("rst_parity_err", 32'(parity_err), 32'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);

    // TX 0xA5 with cycle-exact waveform
    fr = frame_of(8'hA5);
    t_data = 8'hA5; t_valid = 1'b1; tx_q.push_back(8'hA5);
    bad = 0; n_done = 0; done_at = 0;
    for (int k = 1; k <= int'(NB * CPB); k++) begin
      @(negedge clk);
      if (k == 1) begin
        t_valid = 1'b0;
        check("tx_ready_low", 32'(ready), 32'd0);
      end
      if (txd !== fr[(k - 1) / int'(CPB)]) bad++;
      if (tx_done === 1'b1) begin n_done++; done_at = k; end
    end
    check("tx_a5_wave_errs", 32'(bad), 32'd0);
    check("tx_done_pulses", 32'(n_done), 32'd1);
    check("tx_done_cycle", 32'(done_at), 32'(NB * CPB));
    @(negedge clk);
    check("tx_ready_back", 32'(ready), 32'd1);

    // Request while busy is ignored
    wait_ready("ready_before_busy");
    c0 = tx_done_cnt;
    t_data = 8'h12; t_valid = 1'b1; tx_q.push_back(8'h12);
    @(negedge clk);
    t_valid = 1'b0;
    repeat (6) @(negedge clk);
    t_data = 8'hFF; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    check("busy_ready_low", 32'(ready), 32'd0);
    wait_ready("ready_after_busy");
    repeat (NB * CPB + 10) @(negedge clk);
    check("busy_one_done", 32'(tx_done_cnt - c0), 32'd1);
    check("busy_txd_idle", 32'(txd), 32'd1);

    // RX 0x3C
    wait_ready("ready_before_rx");
    c0 = rx_done_cnt;
    rx_q.push_back({1'b0, 8'h3C});
    arm_rx();
    check("rx_armed_ready", 32'(ready), 32'd0);
    send_rx(8'h3C, 1'b1);
    wait_rx("rx_3c_done", c0 + 1);
    check("rx_ready_back", 32'(ready), 32'd1);

    // One-cycle glitch while armed, then a real frame
    c0 = rx_done_cnt;
    arm_rx();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_done", 32'(rx_done_cnt), 32'(c0));
    check("glitch_still_armed", 32'(ready), 32'd0);
    rx_q.push_back({1'b0, 8'hC3});
    send_rx(8'hC3, 1'b1);
    wait_rx("glitch_next_frame", c0 + 1);

    // Full duplex: both requests in one cycle
    wait_ready("ready_before_duplex");
    t_data = 8'h55; t_valid = 1'b1; r_valid = 1'b1;
    tx_q.push_back(8'h55);
    rx_q.push_back({1'b0, 8'h81});
    @(negedge clk);
    t_valid = 1'b0; r_valid = 1'b0;
    gt = 1'b0; gr = 1'b0; bad = 0; n = 0;
    fork
      send_rx(8'h81, 1'b1);
      begin
        while (!(gt && gr) && n < 300) begin
          if (ready === 1'b1) bad++;
          if (tx_done === 1'b1) gt = 1'b1;
          if (rx_done === 1'b1) gr = 1'b1;
          @(negedge clk);
          n++;
        end
        check("duplex_ready_after", 32'(ready), 32'd1);
      end
    join
    check("duplex_tx_done", 32'(gt), 32'd1);
    check("duplex_rx_done", 32'(gr), 32'd1);
    check("duplex_ready_held", 32'(bad), 32'd0);

    // Framing error leaves the receiver armed
    wait_ready("ready_before_frame_err");
    c0 = rx_done_cnt;
    arm_rx();
    send_rx(8'h5A, 1'b0);
    repeat (10) @(negedge clk);
    check("frame_err_no_done", 32'(rx_done_cnt), 32'(c0));
    check("frame_err_armed", 32'(ready), 32'd0);
    rx_q.push_back({1'b0, 8'h77});
    send_rx(8'h77, 1'b1);
    wait_rx("frame_err_recover", c0 + 1);

`ifdef UART_PARITY_EN
    // Bad parity still delivers the byte
    wait_ready("ready_before_parity");
    c0 = rx_done_cnt;
    arm_rx();
    rx_q.push_back({1'b1, 8'h01});
    rx_par_flip = 1'b1;
    send_rx(8'h01, 1'b1);
    rx_par_flip = 1'b0;
    wait_rx("parity_done", c0 + 1);
`endif

    // Reset in the middle of data bit 3
    wait_ready("ready_before_reset_tx");
    t_data = 8'hF0; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("rtx_bit3_low", 32'(txd), 32'd0);
    c0 = tx_done_cnt;
    rstn = 1'b0;
    #1;
    check("rtx_txd_high", 32'(txd), 32'd1);
    check("rtx_ready_low", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (NB * CPB + 5) @(negedge clk);
    check("rtx_no_done", 32'(tx_done_cnt), 32'(c0));
    check("rtx_txd_idle", 32'(txd), 32'd1);
    check("rtx_ready", 32'(ready), 32'd1);

    repeat (10) @(negedge clk);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
